// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: md ALUOp codes,
// FSM state type and operation-decode helpers.
package multdiv_ctrl_pkg;

  localparam logic [4:0] ALU_MULT  = 5'h18;
  localparam logic [4:0] ALU_MULTU = 5'h19;
  localparam logic [4:0] ALU_DIV   = 5'h1A;
  localparam logic [4:0] ALU_DIVU  = 5'h1B;
  localparam logic [4:0] ALU_MADD  = 5'h1C;
  localparam logic [4:0] ALU_MADDU = 5'h1D;
  localparam logic [4:0] ALU_MSUB  = 5'h1E;
  localparam logic [4:0] ALU_MSUBU = 5'h1F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } multdiv_state_t;

  function automatic logic is_md(input logic [4:0] op);
    case (op)
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
      ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU: is_md = 1'b1;
      default:                                  is_md = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_md(input logic [4:0] op);
    case (op)
      ALU_MULT, ALU_DIV, ALU_MADD, ALU_MSUB: is_signed_md = 1'b1;
      default:                              is_signed_md = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    case (op)
      ALU_DIV, ALU_DIVU: is_div_op = 1'b1;
      default:           is_div_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_acc_op(input logic [4:0] op);
    case (op)
      ALU_MADD, ALU_MADDU, ALU_MSUB, ALU_MSUBU: is_acc_op = 1'b1;
      default:                                  is_acc_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_sub_op(input logic [4:0] op);
    case (op)
      ALU_MSUB, ALU_MSUBU: is_sub_op = 1'b1;
      default:             is_sub_op = 1'b0;
    endcase
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    if (sgn && v[31]) abs32 = ~v + 32'd1;
    else              abs32 = v;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// EXE-stage handshake between the pipeline and the multiply/divide sequencer.
interface multdiv_ctrl_if;
  logic        EXE_Valid;
  logic [4:0]  EXE_ALUOp;
  logic [31:0] EXE_ResultA;
  logic [31:0] EXE_ResultB;
  logic [63:0] HiLo_Cur;
  logic        EXE_Wr;
  logic        ExceptionAssert;
  logic        EXE_MULTDIVStall;
  logic        EXE_Finish;
  logic [31:0] EXE_MULTDIVtoHI;
  logic [31:0] EXE_MULTDIVtoLO;

  modport slave (
    input  EXE_Valid, EXE_ALUOp, EXE_ResultA, EXE_ResultB, HiLo_Cur, EXE_Wr, ExceptionAssert,
    output EXE_MULTDIVStall, EXE_Finish, EXE_MULTDIVtoHI, EXE_MULTDIVtoLO
  );

  modport master (
    output EXE_Valid, EXE_ALUOp, EXE_ResultA, EXE_ResultB, HiLo_Cur, EXE_Wr, ExceptionAssert,
    input  EXE_MULTDIVStall, EXE_Finish, EXE_MULTDIVtoHI, EXE_MULTDIVtoLO
  );
endinterface

// File: rtl/multdiv_ctrl_div_radix2.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle. The first
// iteration is taken on the start edge so the result is final when count hits 0.
module multdiv_ctrl_div_radix2 #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [5:0]  count,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvs;
  logic [63:0] step_start;
  logic [63:0] step_run;

  // rem[31] set means the shifted partial remainder exceeds 2^32 > divisor.
  function automatic logic [63:0] div_step(input logic [31:0] rem, input logic [31:0] quo,
                                           input logic [31:0] d);
    logic [31:0] shifted;
    shifted = {rem[30:0], quo[31]};
    if (rem[31] || (shifted >= d)) div_step = {shifted - d, quo[30:0], 1'b1};
    else                           div_step = {shifted, quo[30:0], 1'b0};
  endfunction

  assign step_start = div_step(32'd0, dividend, divisor);
  assign step_run   = div_step(remainder, quotient, dvs);

  // Iteration register: load on start, shift one bit per busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      count     <= 6'd0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
      dvs       <= 32'd0;
    end else if (abort) begin
      busy      <= 1'b0;
      count     <= 6'd0;
      quotient  <= 32'd0;
      remainder <= 32'd0;
      dvs       <= 32'd0;
    end else if (start) begin
      {remainder, quotient} <= step_start;
      dvs   <= divisor;
      count <= 6'(ITER - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == 6'd0) begin
        busy <= 1'b0;
      end else begin
        {remainder, quotient} <= step_run;
        count <= count - 6'd1;
      end
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// EXE-stage multiply/divide sequencer: issues md ops, stalls the front end,
// runs the pipelined multiplier or iterative divider, and holds {HI,LO}.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input logic            clk,
  input logic            rst,
  multdiv_ctrl_if.slave  bus
);

  multdiv_state_t state, next_state;

  logic [5:0]  cnt;
  logic [4:0]  op;
  logic [31:0] mag_a, mag_b, dvd_raw;
  logic        neg, rem_neg, div_zero;
  logic [63:0] hilo;

  logic        md_req, issue, in_signed;
  logic [31:0] in_mag_a, in_mag_b;

  logic        div_start, div_busy, div_done;
  logic [5:0]  div_count;
  logic [31:0] div_quo, div_rem, quo_fix, rem_fix;
  logic [63:0] div_fix;

  logic [63:0] mul_raw, mul_out, mul_fix;
  logic        mul_first, mul_last;

  assign md_req    = bus.EXE_Valid & is_md(bus.EXE_ALUOp) & ~bus.ExceptionAssert;
  assign issue     = md_req & (state == IDLE);
  assign in_signed = is_signed_md(bus.EXE_ALUOp);
  assign in_mag_a  = abs32(bus.EXE_ResultA, in_signed);
  assign in_mag_b  = abs32(bus.EXE_ResultB, in_signed);

  assign bus.EXE_MULTDIVStall = md_req & (state != DONE);
  assign bus.EXE_Finish       = (state == DONE);
  assign bus.EXE_MULTDIVtoHI  = hilo[63:32];
  assign bus.EXE_MULTDIVtoLO  = hilo[31:0];

  assign div_start = issue & is_div_op(bus.EXE_ALUOp);
  assign div_done  = (state == DIV) & div_busy & (div_count == 6'd0);

  multdiv_ctrl_div_radix2 #(.ITER(DIV_ITER)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (bus.ExceptionAssert),
    .dividend  (in_mag_a),
    .divisor   (in_mag_b),
    .busy      (div_busy),
    .count     (div_count),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign quo_fix = neg ? (~div_quo + 32'd1) : div_quo;
  assign rem_fix = rem_neg ? (~div_rem + 32'd1) : div_rem;
  assign div_fix = div_zero ? {dvd_raw, 32'hFFFF_FFFF} : {rem_fix, quo_fix};

  assign mul_raw   = {32'd0, mag_a} * {32'd0, mag_b};
  assign mul_first = (state == MUL) & (cnt == 6'(MUL_LAT - 1));
  assign mul_fix   = neg ? (~mul_out + 64'd1) : mul_out;

  // The HI/LO register is the last multiplier stage; earlier stages shift here.
  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign mul_out  = mul_raw;
      assign mul_last = mul_first;
    end else begin : g_latn
      logic [63:0]        pipe [MUL_LAT-1];
      logic [MUL_LAT-2:0] vld;

      // Product and valid-bit shift chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int k = 0; k < MUL_LAT - 1; k++) pipe[k] <= 64'd0;
        end else if (bus.ExceptionAssert) begin
          vld <= '0;
        end else begin
          vld[0]  <= mul_first;
          pipe[0] <= mul_raw;
          for (int k = 1; k < MUL_LAT - 1; k++) begin
            vld[k]  <= vld[k-1];
            pipe[k] <= pipe[k-1];
          end
        end
      end

      assign mul_out  = pipe[MUL_LAT-2];
      assign mul_last = vld[MUL_LAT-2] & (state == MUL);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a flush overrides every transition.
  always_comb begin
    next_state = state;
    if (bus.ExceptionAssert) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) next_state = is_div_op(bus.EXE_ALUOp) ? DIV : MUL;
          else       next_state = IDLE;
        end
        MUL: begin
          if (cnt == 6'd0) next_state = is_acc_op(op) ? ACC : DONE;
          else             next_state = MUL;
        end
        DIV: begin
          if (div_done) next_state = DONE;
          else          next_state = DIV;
        end
        ACC:  next_state = DONE;
        DONE: begin
          if (bus.EXE_Wr) next_state = IDLE;
          else            next_state = DONE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Operand latch, multiplier countdown and HI/LO result; results survive a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= 5'd0;
      mag_a    <= 32'd0;
      mag_b    <= 32'd0;
      dvd_raw  <= 32'd0;
      neg      <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= 6'd0;
      hilo     <= 64'd0;
    end else if (bus.ExceptionAssert) begin
      cnt <= 6'd0;
    end else begin
      if (issue) begin
        op       <= bus.EXE_ALUOp;
        mag_a    <= in_mag_a;
        mag_b    <= in_mag_b;
        dvd_raw  <= bus.EXE_ResultA;
        neg      <= in_signed & (bus.EXE_ResultA[31] ^ bus.EXE_ResultB[31]);
        rem_neg  <= in_signed & bus.EXE_ResultA[31];
        div_zero <= (bus.EXE_ResultB == 32'd0);
        cnt      <= is_div_op(bus.EXE_ALUOp) ? 6'd0 : 6'(MUL_LAT - 1);
      end else if ((state == MUL) && (cnt != 6'd0)) begin
        cnt <= cnt - 6'd1;
      end

      if (mul_last)            hilo <= mul_fix;
      else if (state == ACC)   hilo <= is_sub_op(op) ? (bus.HiLo_Cur - hilo) : (bus.HiLo_Cur + hilo);
      else if (div_done)       hilo <= div_fix;
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with MUL_LAT=2, DIV_ITER=32.
module tb_multdiv_ctrl;
  import multdiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multdiv_ctrl_if bus();

  multdiv_ctrl #(.MUL_LAT(2), .DIV_ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.EXE_Valid       = 1'b0;
    bus.EXE_ALUOp       = 5'h00;
    bus.EXE_ResultA     = 32'd0;
    bus.EXE_ResultB     = 32'd0;
    bus.HiLo_Cur        = 64'd0;
    bus.EXE_Wr          = 1'b0;
    bus.ExceptionAssert = 1'b0;
  endtask

  function automatic logic [63:0] hilo_out();
    return {bus.EXE_MULTDIVtoHI, bus.EXE_MULTDIVtoLO};
  endfunction

  // Issue one op, check stall/finish every cycle up to DONE, hold, then retire it.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] acc, input int lat,
                        input logic [63:0] exp, input int hold);
    bus.EXE_Valid   = 1'b1;
    bus.EXE_ALUOp   = op;
    bus.EXE_ResultA = a;
    bus.EXE_ResultB = b;
    bus.HiLo_Cur    = acc;
    bus.EXE_Wr      = 1'b0;
    #1;
    check_val({tag, " stall@issue"}, 64'(bus.EXE_MULTDIVStall), 64'd1);
    for (int k = 1; k <= lat; k++) begin
      tick();
      bus.EXE_ResultA = 32'hDEAD_BEEF;
      bus.EXE_ResultB = 32'h0BAD_F00D;
      if (k < lat) begin
        check_val({tag, " finish early"}, 64'(bus.EXE_Finish), 64'd0);
        check_val({tag, " stall busy"}, 64'(bus.EXE_MULTDIVStall), 64'd1);
      end else begin
        check_val({tag, " finish"}, 64'(bus.EXE_Finish), 64'd1);
        check_val({tag, " stall done"}, 64'(bus.EXE_MULTDIVStall), 64'd0);
        check_val({tag, " result"}, hilo_out(), exp);
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val({tag, " hold finish"}, 64'(bus.EXE_Finish), 64'd1);
      check_val({tag, " hold stall"}, 64'(bus.EXE_MULTDIVStall), 64'd0);
      check_val({tag, " hold result"}, hilo_out(), exp);
    end
    bus.EXE_Wr = 1'b1;
    tick();
    bus.EXE_Wr    = 1'b0;
    bus.EXE_Valid = 1'b0;
    check_val({tag, " retire"}, 64'(bus.EXE_Finish), 64'd0);
  endtask

  initial begin
    logic fin_seen;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset finish", 64'(bus.EXE_Finish), 64'd0);
    check_val("reset stall", 64'(bus.EXE_MULTDIVStall), 64'd0);
    check_val("reset hilo", hilo_out(), 64'd0);

    run_op("mult",  ALU_MULT,  32'hFFFF_FFFE, 32'd3,         64'd0, 3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    run_op("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 3, 64'hFFFF_FFFE_0000_0001, 0);
    run_op("divu",  ALU_DIVU,  32'd100,       32'd7,         64'd0, 33, 64'h0000_0002_0000_000E, 0);
    run_op("div neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2,         64'd0, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 33, 64'h0000_0000_8000_0000, 0);
    run_op("divu z", ALU_DIVU, 32'd5,         32'd0,         64'd0, 33, 64'h0000_0005_FFFF_FFFF, 0);
    run_op("div z",  ALU_DIV,  32'hFFFF_FFFB, 32'd0,         64'd0, 33, 64'hFFFF_FFFB_FFFF_FFFF, 0);
    run_op("maddu", ALU_MADDU, 32'd2, 32'd2, 64'h0000_0001_FFFF_FFFF, 4, 64'h0000_0002_0000_0003, 0);
    run_op("msub",  ALU_MSUB,  32'hFFFF_FFFF, 32'd1,         64'd0,  4, 64'h0000_0000_0000_0001, 0);
    run_op("madd",  ALU_MADD,  32'd3,         32'hFFFF_FFFC, 64'd10, 4, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("msubu", ALU_MSUBU, 32'd1,         32'd1,         64'd0,  4, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("hold",  ALU_MULT,  32'd7,         32'd6,         64'd0,  3, 64'h0000_0000_0000_002A, 5);

    // Flush at t+10 of a divide: back to IDLE, result registers untouched.
    bus.EXE_Valid   = 1'b1;
    bus.EXE_ALUOp   = ALU_DIV;
    bus.EXE_ResultA = 32'd100;
    bus.EXE_ResultB = 32'd7;
    #1;
    check_val("flush issue stall", 64'(bus.EXE_MULTDIVStall), 64'd1);
    repeat (10) tick();
    bus.ExceptionAssert = 1'b1;
    #1;
    check_val("flush stall", 64'(bus.EXE_MULTDIVStall), 64'd0);
    tick();
    bus.ExceptionAssert = 1'b0;
    bus.EXE_Valid       = 1'b0;
    check_val("flush finish", 64'(bus.EXE_Finish), 64'd0);
    check_val("flush keeps hilo", hilo_out(), 64'h0000_0000_0000_002A);
    fin_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.EXE_Finish) fin_seen = 1'b1;
    end
    check_val("flush no finish", 64'(fin_seen), 64'd0);
    run_op("div after flush", ALU_DIV, 32'd9, 32'd3, 64'd0, 33, 64'h0000_0000_0000_0003, 0);

    // Flush in the issue cycle: no start.
    bus.EXE_Valid       = 1'b1;
    bus.EXE_ALUOp       = ALU_MULT;
    bus.EXE_ResultA     = 32'd5;
    bus.EXE_ResultB     = 32'd5;
    bus.ExceptionAssert = 1'b1;
    #1;
    check_val("exc issue stall", 64'(bus.EXE_MULTDIVStall), 64'd0);
    tick();
    bus.ExceptionAssert = 1'b0;
    bus.EXE_Valid       = 1'b0;
    fin_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.EXE_Finish) fin_seen = 1'b1;
    end
    check_val("exc issue no finish", 64'(fin_seen), 64'd0);
    check_val("exc issue hilo", hilo_out(), 64'h0000_0000_0000_0003);

    // Non-md op in EXE: no stall, no start.
    bus.EXE_Valid = 1'b1;
    bus.EXE_ALUOp = 5'h00;
    #1;
    check_val("non-md stall", 64'(bus.EXE_MULTDIVStall), 64'd0);
    fin_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.EXE_Finish) fin_seen = 1'b1;
    end
    check_val("non-md no finish", 64'(fin_seen), 64'd0);
    bus.EXE_Valid = 1'b0;

    // Reset in the middle of a divide.
    bus.EXE_Valid   = 1'b1;
    bus.EXE_ALUOp   = ALU_DIVU;
    bus.EXE_ResultA = 32'd100;
    bus.EXE_ResultB = 32'd7;
    repeat (5) tick();
    rst           = 1'b1;
    bus.EXE_Valid = 1'b0;
    #1;
    check_val("rst mid finish", 64'(bus.EXE_Finish), 64'd0);
    check_val("rst mid hilo", hilo_out(), 64'd0);
    tick();
    rst = 1'b0;
    fin_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.EXE_Finish) fin_seen = 1'b1;
    end
    check_val("rst mid no finish", 64'(fin_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
